// File: rtl/gemm_tile_controller_if.sv
// ============================================================================
// Module   : gemm_tile_controller_if
// Purpose  : Start/size handshake and tile-sequencing bus of the GEMM tile
//            controller; slave = controller side, master = job issuer/consumer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface gemm_tile_controller_if #(
    parameter int RowPar        = 4,
    parameter int ColPar        = 16,
    parameter int SizeAddrWidth = 32,
    parameter int AddrWidth     = 12
);
    logic                     start_i;
    logic [SizeAddrWidth-1:0] M_size_i;
    logic [SizeAddrWidth-1:0] K_size_i;
    logic [SizeAddrWidth-1:0] N_size_i;
    logic                     busy_o;
    logic                     done_o;
    logic [SizeAddrWidth-1:0] m_base_o;
    logic [SizeAddrWidth-1:0] n_base_o;
    logic [SizeAddrWidth-1:0] k_idx_o;
    logic                     pe_valid_o;
    logic                     pe_clear_o;
    logic [RowPar-1:0]        row_mask_o;
    logic [ColPar-1:0]        col_mask_o;
    logic                     c_we_o;
    logic [AddrWidth-1:0]     c_addr_o;
    logic [31:0]              perf_cycles_o;

    modport slave (
        input  start_i, M_size_i, K_size_i, N_size_i,
        output busy_o, done_o, m_base_o, n_base_o, k_idx_o, pe_valid_o,
               pe_clear_o, row_mask_o, col_mask_o, c_we_o, c_addr_o,
               perf_cycles_o
    );

    modport master (
        output start_i, M_size_i, K_size_i, N_size_i,
        input  busy_o, done_o, m_base_o, n_base_o, k_idx_o, pe_valid_o,
               pe_clear_o, row_mask_o, col_mask_o, c_we_o, c_addr_o,
               perf_cycles_o
    );
endinterface

`default_nettype wire

// File: rtl/gemm_tile_controller.sv
// ============================================================================
// Module   : gemm_tile_controller
// Purpose  : Output-stationary GEMM tile sequencer (M tiles outer, N inner,
//            K reduction per tile). Optional busy-cycle counter: GEMM_CTRL_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gemm_tile_controller #(
    parameter int RowPar        = 4,
    parameter int ColPar        = 16,
    parameter int SizeAddrWidth = 32,
    parameter int AddrWidth     = 12
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    gemm_tile_controller_if.slave  bus
);

    typedef logic [SizeAddrWidth-1:0] size_t;
    typedef logic [SizeAddrWidth:0]   ext_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_DRAIN = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t state_q, state_d;
    size_t  m_size_q, m_size_d;
    size_t  k_size_q, k_size_d;
    size_t  n_size_q, n_size_d;
    size_t  m_base_q, m_base_d;
    size_t  n_base_q, n_base_d;
    size_t  k_q, k_d;
    logic   pe_valid_q, pe_valid_d;
    logic   pe_clear_q, pe_clear_d;

    ext_t   n_next;
    ext_t   m_next;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            m_size_q   <= '0;
            k_size_q   <= '0;
            n_size_q   <= '0;
            m_base_q   <= '0;
            n_base_q   <= '0;
            k_q        <= '0;
            pe_valid_q <= 1'b0;
            pe_clear_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            m_size_q   <= m_size_d;
            k_size_q   <= k_size_d;
            n_size_q   <= n_size_d;
            m_base_q   <= m_base_d;
            n_base_q   <= n_base_d;
            k_q        <= k_d;
            pe_valid_q <= pe_valid_d;
            pe_clear_q <= pe_clear_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        m_size_d   = m_size_q;
        k_size_d   = k_size_q;
        n_size_d   = n_size_q;
        m_base_d   = m_base_q;
        n_base_d   = n_base_q;
        k_d        = k_q;
        // Tile advance is evaluated one bit wider so it can never wrap.
        n_next     = ext_t'(n_base_q) + ext_t'(ColPar);
        m_next     = ext_t'(m_base_q) + ext_t'(RowPar);
        // SRAM read issued in RUN lands at the PEs one cycle later.
        pe_valid_d = (state_q == S_RUN);
        pe_clear_d = (state_q == S_RUN) && (k_q == '0);

        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    m_size_d = bus.M_size_i;
                    k_size_d = bus.K_size_i;
                    n_size_d = bus.N_size_i;
                    m_base_d = '0;
                    n_base_d = '0;
                    k_d      = '0;
                    if ((bus.M_size_i == '0) || (bus.K_size_i == '0) ||
                        (bus.N_size_i == '0)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (k_q == (k_size_q - size_t'(1))) begin
                    k_d     = '0;
                    state_d = S_DRAIN;
                end else begin
                    k_d = k_q + size_t'(1);
                end
            end
            S_DRAIN: begin
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (n_next >= ext_t'(n_size_q)) begin
                    n_base_d = '0;
                    m_base_d = m_next[SizeAddrWidth-1:0];
                    if (m_next >= ext_t'(m_size_q)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end else begin
                    n_base_d = n_next[SizeAddrWidth-1:0];
                    state_d  = S_RUN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    logic [RowPar-1:0] row_mask;
    logic [ColPar-1:0] col_mask;

    always_comb begin
        row_mask = '0;
        col_mask = '0;
        for (int r = 0; r < RowPar; r++) begin
            row_mask[r] = (ext_t'(m_base_q) + ext_t'(r)) < ext_t'(m_size_q);
        end
        for (int c = 0; c < ColPar; c++) begin
            col_mask[c] = (ext_t'(n_base_q) + ext_t'(c)) < ext_t'(n_size_q);
        end
    end

    // Only the low AddrWidth bits of the product survive, so multiply narrow.
    logic [AddrWidth-1:0] c_addr;
    assign c_addr = m_base_q[AddrWidth-1:0] * n_size_q[AddrWidth-1:0]
                  + n_base_q[AddrWidth-1:0];

`ifdef GEMM_CTRL_PERF_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if ((state_q == S_IDLE) && bus.start_i) begin
            perf_d = '0;
        end else if ((state_q != S_IDLE) && (perf_q != 32'hFFFF_FFFF)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign bus.perf_cycles_o = perf_q;
`else
    assign bus.perf_cycles_o = '0;
`endif

    assign bus.busy_o     = (state_q != S_IDLE);
    assign bus.done_o     = (state_q == S_DONE);
    assign bus.c_we_o     = (state_q == S_WRITE);
    assign bus.m_base_o   = m_base_q;
    assign bus.n_base_o   = n_base_q;
    assign bus.k_idx_o    = k_q;
    assign bus.pe_valid_o = pe_valid_q;
    assign bus.pe_clear_o = pe_clear_q;
    assign bus.row_mask_o = row_mask;
    assign bus.col_mask_o = col_mask;
    assign bus.c_addr_o   = c_addr;

endmodule

`default_nettype wire

// File: tb/tb_gemm_tile_controller.sv
// ============================================================================
// Module   : tb_gemm_tile_controller
// Purpose  : Scoreboard bench for gemm_tile_controller: a tile-loop model
//            queues expected C writes and done events, a monitor pops them.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gemm_tile_controller;
    localparam int RP = 4;
    localparam int CP = 16;
    localparam int SW = 32;
    localparam int AW = 12;

    logic clk = 1'b0;
    logic rst;

    gemm_tile_controller_if #(.RowPar(RP), .ColPar(CP), .SizeAddrWidth(SW), .AddrWidth(AW)) bus ();

    gemm_tile_controller #(.RowPar(RP), .ColPar(CP), .SizeAddrWidth(SW), .AddrWidth(AW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        int unsigned m;
        int unsigned n;
        int unsigned addr;
        int unsigned rmask;
        int unsigned cmask;
        int unsigned k;
    } wr_t;

    typedef struct {
        int unsigned cyc;
        int unsigned perf;
    } dn_t;

    wr_t wq[$];
    dn_t dq[$];

    int unsigned cyc = 0;
    int errors = 0;
    int checks = 0;

    int unsigned vcnt = 0;
    bit          perf_pend = 0;
    int unsigned perf_exp = 0;
    logic [SW-1:0] prev_k = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event seen, expected none (cycle %0d)", name, cyc);
    endtask

    // Reference model: plain tile loops over the job.
    task automatic push_job(input int unsigned c, input int unsigned M, input int unsigned K,
                            input int unsigned N, output int unsigned total);
        int unsigned t;
        wr_t e;
        dn_t d;
        t = 0;
        if (M == 0 || K == 0 || N == 0) begin
            total = 1;
        end else begin
            for (int unsigned m = 0; m < M; m += RP) begin
                for (int unsigned n = 0; n < N; n += CP) begin
                    e.cyc   = c + (t + 1) * (K + 2);
                    e.m     = m;
                    e.n     = n;
                    e.addr  = (m * N + n) % (1 << AW);
                    e.rmask = 0;
                    e.cmask = 0;
                    for (int r = 0; r < RP; r++) if (m + r < M) e.rmask |= (1 << r);
                    for (int q = 0; q < CP; q++) if (n + q < N) e.cmask |= (1 << q);
                    e.k     = K;
                    wq.push_back(e);
                    t++;
                end
            end
            total = t * (K + 2) + 1;
        end
        d.cyc = c + total;
`ifdef GEMM_CTRL_PERF_EN
        d.perf = total;
`else
        d.perf = 0;
`endif
        dq.push_back(d);
    endtask

    // Monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (perf_pend) begin
                chk("perf_cycles", bus.perf_cycles_o, perf_exp);
                perf_pend = 0;
            end
            if (bus.pe_clear_o) begin
                chk("pe_clear_needs_valid", bus.pe_valid_o, 1);
                chk("pe_clear_first_step", vcnt, 0);
            end
            if (bus.pe_valid_o) begin
                if (vcnt == 0) chk("pe_clear_on_first", bus.pe_clear_o, 1);
                chk("k_idx_issue", prev_k, vcnt);
                vcnt++;
            end
            if (bus.c_we_o) begin
                if (wq.size() == 0) begin
                    unexpected("c_we");
                end else begin
                    wr_t e;
                    e = wq.pop_front();
                    chk("c_we_cycle", cyc, e.cyc);
                    chk("m_base", bus.m_base_o, e.m);
                    chk("n_base", bus.n_base_o, e.n);
                    chk("c_addr", bus.c_addr_o, e.addr);
                    chk("row_mask", bus.row_mask_o, e.rmask);
                    chk("col_mask", bus.col_mask_o, e.cmask);
                    chk("pe_valid_count", vcnt, e.k);
                end
                vcnt = 0;
            end
            if (bus.done_o) begin
                if (dq.size() == 0) begin
                    unexpected("done");
                end else begin
                    dn_t d;
                    d = dq.pop_front();
                    chk("done_cycle", cyc, d.cyc);
                    chk("writes_left_at_done", wq.size(), 0);
                    chk("pe_valid_after_write", vcnt, 0);
                    chk("busy_at_done", bus.busy_o, 1);
                    perf_exp  = d.perf;
                    perf_pend = 1;
                end
            end
            prev_k = bus.k_idx_o;
        end
    end

    task automatic run_job(input int unsigned M, input int unsigned K, input int unsigned N,
                           input bit mid);
        int unsigned total;
        @(negedge clk);
        push_job(cyc, M, K, N, total);
        bus.start_i  = 1'b1;
        bus.M_size_i = M;
        bus.K_size_i = K;
        bus.N_size_i = N;
        @(posedge clk);
        #1;
        bus.start_i  = 1'b0;
        bus.M_size_i = $urandom;
        bus.K_size_i = $urandom;
        bus.N_size_i = $urandom;
        if (mid && total > 4) begin
            repeat (2) @(posedge clk);
            #1;
            bus.start_i  = 1'b1;
            bus.M_size_i = $urandom_range(1, 20);
            bus.K_size_i = $urandom_range(1, 9);
            bus.N_size_i = $urandom_range(1, 50);
            @(posedge clk);
            #1;
            bus.start_i = 1'b0;
        end
        for (int i = 0; i < int'(total) + 20 && (wq.size() != 0 || dq.size() != 0); i++) begin
            @(negedge clk);
            #1;
        end
        if (wq.size() != 0 || dq.size() != 0) begin
            unexpected("job_timeout");
            wq.delete();
            dq.delete();
        end
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst          = 1'b1;
        bus.start_i  = 1'b0;
        bus.M_size_i = '0;
        bus.K_size_i = '0;
        bus.N_size_i = '0;
        #12;
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_done", bus.done_o, 0);
        chk("rst_pe", {bus.pe_valid_o, bus.pe_clear_o, bus.c_we_o}, 0);
        chk("rst_masks", {bus.row_mask_o, bus.col_mask_o}, 0);
        chk("rst_addr_perf", {bus.c_addr_o, bus.perf_cycles_o}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_job(4, 64, 16, 0);
        run_job(8, 3, 32, 0);
        run_job(5, 2, 17, 0);
        run_job(4, 0, 16, 0);
        run_job(8, 3, 32, 1);

        // Asynchronous abort in the middle of RUN
        @(negedge clk);
        bus.start_i  = 1'b1;
        bus.M_size_i = 8;
        bus.K_size_i = 10;
        bus.N_size_i = 32;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        chk("busy_before_abort", bus.busy_o, 1);
        chk("k_idx_before_abort", bus.k_idx_o, 4);
        rst = 1'b1;
        #1;
        chk("abort_busy", bus.busy_o, 0);
        chk("abort_k_idx", bus.k_idx_o, 0);
        chk("abort_pe", {bus.pe_valid_o, bus.pe_clear_o, bus.c_we_o, bus.done_o}, 0);
        chk("abort_bases", {bus.m_base_o, bus.n_base_o}, 0);
        chk("abort_masks_addr", {bus.row_mask_o, bus.col_mask_o, bus.c_addr_o}, 0);
        vcnt      = 0;
        perf_pend = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        run_job(5, 2, 17, 0);

        for (int j = 0; j < 20; j++) begin
            int unsigned m, k, n;
            m = $urandom_range(1, 12);
            k = $urandom_range(1, 6);
            n = $urandom_range(1, 40);
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 2))
                    0: m = 0;
                    1: k = 0;
                    default: n = 0;
                endcase
            end
            run_job(m, k, n, 1'($urandom_range(0, 1)));
        end

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/gemm_tile_controller.md
Name: gemm_tile_controller

Overview:
- Sequencing FSM for the RowPar x ColPar output-stationary GEMM array in gemm_accelerator_top.
- Walks C in output tiles: M tiles in the outer loop, N tiles in the inner loop, with a K reduction per tile.
- Drives tile base indices, the K index, PE valid/clear strobes, edge masks, the C write strobe and the start/done handshake.
- Per-port SRAM address arithmetic lives in the downstream address unit, which consumes these outputs.

Parameters:
- RowPar, 4, PE rows (M elements per tile).
- ColPar, 16, PE columns (N elements per tile).
- SizeAddrWidth, 32, width of M/K/N size inputs and of internal loop counters.
- AddrWidth, 12, width of c_addr_o.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  start request; honoured only in IDLE.
- M_size_i  in  SizeAddrWidth  rows of A/C.
- K_size_i  in  SizeAddrWidth  reduction depth.
- N_size_i  in  SizeAddrWidth  columns of B/C.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse at job end.
- m_base_o  out  SizeAddrWidth  first C row of the current tile.
- n_base_o  out  SizeAddrWidth  first C column of the current tile.
- k_idx_o  out  SizeAddrWidth  K index whose A/B read is issued this cycle.
- pe_valid_o  out  1  SRAM read data valid at the PEs this cycle; PEs accumulate.
- pe_clear_o  out  1  with pe_valid_o: PEs load the product instead of accumulating.
- row_mask_o  out  RowPar  bit r = 1 when row m_base+r < M.
- col_mask_o  out  ColPar  bit c = 1 when column n_base+c < N.
- c_we_o  out  1  write the tile accumulators to C this cycle.
- c_addr_o  out  AddrWidth  row-major C base address = m_base*N + n_base, truncated to AddrWidth.
- perf_cycles_o  out  32  busy-cycle count (see Optional Feature).

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Reset is asynchronous and may arrive mid-job; it aborts with no done_o pulse.
- States: IDLE, RUN, DRAIN, WRITE, DONE.
- IDLE:
  - start_i=1 latches M/K/N and clears m_base, n_base and k.
  - If any size is 0, go to DONE; no c_we_o is ever issued.
  - Otherwise go to RUN.
- RUN:
  - k_idx_o = k; k increments every cycle.
  - When k = K-1, go to DRAIN and reset k to 0.
- SRAM read latency is 1 cycle:
  - pe_valid_o = RUN registered by one cycle, so it is high for exactly K consecutive cycles per tile.
  - pe_clear_o = pe_valid_o on the first K step of each tile.
- DRAIN: one cycle. The last pe_valid_o occurs here; go to WRITE.
- WRITE: c_we_o=1 for exactly one cycle, with c_addr_o, masks and bases describing the finished tile. Then advance the tile:
  - n_base += ColPar.
  - If the new n_base >= N: n_base=0 and m_base += RowPar.
  - If the new m_base >= M: go to DONE; else go to RUN.
- DONE: done_o=1 for one cycle, then IDLE.
- Masks are combinational from bases and latched sizes. Full tiles give all ones; edge tiles clear the out-of-range bits.
- Latency: ceil(M/RowPar) * ceil(N/ColPar) * (K+2) + 1 cycles from the start-accept edge to the done_o cycle.
- start_i while busy_o=1 is ignored; latched sizes stay fixed for the whole job.
- start_i in the same cycle as done_o is ignored; the next start is accepted from IDLE.
- Counter compares use full SizeAddrWidth with no wrap. Sizes must satisfy M*N <= 2^AddrWidth; larger sizes are not detected.

Optional Feature:
- Macro: GEMM_CTRL_PERF_EN.
- Defined:
  - perf_cycles_o counts cycles with busy_o=1 and saturates at 2^32-1.
  - It clears on an accepted start and holds its value in IDLE.
- Undefined: perf_cycles_o is tied to 0 and no counter flops exist.

Test Plan:
- M=4,K=64,N=16 -> one tile; pe_valid_o high 64 cycles with pe_clear_o on the first; a single c_we_o with c_addr_o=0; masks 4'hF / 16'hFFFF; done_o 67 cycles after start.
- M=8,K=3,N=32 -> 4 tiles in order (m,n) = (0,0),(0,16),(4,0),(4,16); c_addr_o = 0,16,128,144; done_o after 4*5+1 = 21 cycles; perf_cycles_o=21 when enabled.
- M=5,K=2,N=17 -> 4 tiles; tile (4,16) has row_mask_o=4'b0001 and col_mask_o=16'h0001 with c_addr_o=84; tile (0,16) has row_mask_o=4'hF and col_mask_o=16'h0001.
- K=0 (M=4,N=16) -> done_o one cycle after start; no pe_valid_o and no c_we_o.
- start_i pulsed again mid-job with different sizes -> ignored; the original tile sequence and done_o timing are unchanged.
- rst_i asserted during RUN -> all outputs 0 immediately (asynchronous), no done_o; a new start then completes normally.
